// File: rtl/prio_enc_pkg.sv
// Shared types and constants for the prio_encoder_arb request arbiter.
package prio_enc_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   localparam int unsigned      CNT_W   = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/prio_encoder_arb_if.sv
// Request/grant bundle between requesters (master) and the prio_encoder_arb arbiter (slave).
interface prio_encoder_arb_if #(
   parameter int unsigned N = 32
) ();
   import prio_enc_pkg::*;

   localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]     req_in;
   logic             enc_en;
   logic             release_in;
   logic [W-1:0]     enc_out;
   logic [N-1:0]     grant_onehot;
   logic             valid_out;
   logic [CNT_W-1:0] grant_count;

   modport master (
      output req_in, enc_en, release_in,
      input  enc_out, grant_onehot, valid_out, grant_count
   );

   modport slave (
      input  req_in, enc_en, release_in,
      output enc_out, grant_onehot, valid_out, grant_count
   );

endinterface

// File: rtl/prio_pick.sv
// Combinational priority pick: first set request searching downward from start, wrapping
// from 0 back to N-1.
module prio_pick #(
   parameter int unsigned N = 32,
   localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic [W-1:0] idx,
   output logic         found
);

   always_comb begin
      int unsigned pos;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int unsigned i = 0; i < N; i++) begin
         // start + N - i never underflows; one subtraction folds it back into 0..N-1.
         pos = 32'(start) + N - i;
         if (pos >= N) begin
            pos = pos - N;
         end
         if (!found && (pos < N) && req[pos[W-1:0]]) begin
            found = 1'b1;
            idx   = pos[W-1:0];
         end
      end
   end

endmodule

// File: rtl/prio_encoder_arb.sv
// Registered N-way arbiter, fixed or round-robin priority, grant held until released.
// Define PRIO_ENC_STATS_EN to build the saturating grant counter.
module prio_encoder_arb
   import prio_enc_pkg::*;
#(
   parameter int unsigned N           = 32,
   parameter int unsigned ROUND_ROBIN = 0
) (
   input logic               clk,
   input logic               clr_n,
   prio_encoder_arb_if.slave bus
);

   localparam int unsigned W    = (N > 1) ? $clog2(N) : 1;
   localparam logic [W-1:0] LAST = W'(N - 1);

   state_e         state_q, state_d;
   logic [W-1:0]   enc_q, enc_d;
   logic [W-1:0]   ptr_q, ptr_d;
   logic [N-1:0]   grant_q, grant_d;
   logic           valid_q, valid_d;
   logic [W-1:0]   pick_start;
   logic [W-1:0]   pick_idx;
   logic           pick_found;

   // Fixed mode always searches from the top index; ptr then never moves.
   assign pick_start = (ROUND_ROBIN != 0) ? ptr_q : LAST;

   prio_pick #(
      .N (N)
   ) u_pick (
      .req   (bus.req_in),
      .start (pick_start),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      state_d = state_q;
      enc_d   = enc_q;
      grant_d = grant_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (bus.enc_en && pick_found) begin
               state_d = GRANT;
               enc_d   = pick_idx;
               grant_d = N'(1) << pick_idx;
               valid_d = 1'b1;
               if (ROUND_ROBIN != 0) begin
                  ptr_d = (pick_idx == '0) ? LAST : pick_idx - 1'b1;
               end
            end
         end
         GRANT: begin
            // No preemption: only the owner's release or loss of its request ends the grant.
            if (bus.release_in || !bus.req_in[enc_q]) begin
               state_d = IDLE;
               enc_d   = '0;
               grant_d = '0;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= IDLE;
         enc_q   <= '0;
         grant_q <= '0;
         valid_q <= 1'b0;
         ptr_q   <= LAST;
      end else begin
         state_q <= state_d;
         enc_q   <= enc_d;
         grant_q <= grant_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.enc_out      = enc_q;
   assign bus.grant_onehot = grant_q;
   assign bus.valid_out    = valid_q;

`ifdef PRIO_ENC_STATS_EN
   logic [CNT_W-1:0] cnt_q;
   logic             grant_evt;

   assign grant_evt = (state_q == IDLE) && (state_d == GRANT);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         cnt_q <= '0;
      end else if (grant_evt && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.grant_count = cnt_q;
`else
   assign bus.grant_count = '0;
`endif

endmodule
